mux2a1_arbiter: RTL and testbench
=================================

// Module: mux2a1_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 2:1 mux datapath (mux2a1).
//   Two requesters contend for one output channel. The block grants one requester
//   at a time, drives the mux select from a register, and holds the grant for a
//   burst. The output side uses a valid/ready handshake.
// PARAMETERS
//   WIDTH      8   data width per requester (one mux2a1 slice per bit)
//   MAX_BURST  4   max accepted transfers per grant; 0 = unlimited
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   req0       in   1      requester 0 wants the channel (level)
//   req1       in   1      requester 1 wants the channel (level)
//   d0         in   WIDTH  requester 0 data
//   d1         in   WIDTH  requester 1 data
//   last0      in   1      requester 0 marks final beat of its burst
//   last1      in   1      requester 1 marks final beat of its burst
//   out_ready  in   1      downstream accepts out_data this cycle
//   gnt0       out  1      requester 0 owns the channel (registered)
//   gnt1       out  1      requester 1 owns the channel (registered)
//   sel        out  1      registered mux select (0 = d0, 1 = d1)
//   out_valid  out  1      out_data valid = granted req still asserted
//   out_data   out  WIDTH  mux2a1 output, combinational from sel and d0/d1
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE; gnt0=gnt1=0; sel=0; busy=0; beat count=0; priority pointer favours req0.
//     out_valid=0 and out_data=d0 follow from the reset state.
//   - States: IDLE, GNT0, GNT1. gnt0/gnt1 and sel are decoded from registered state, so they are glitch-free.
//   - Arbitration latency is 1 cycle: a req seen in IDLE gives its grant on the next edge.
//     If both requesters are asserted, the requester the pointer favours wins.
//   - out_valid = (GNT0 & req0) | (GNT1 & req1). A transfer is a cycle with out_valid & out_ready.
//   - Each transfer increments the beat count.
//   - The grant is released at the end of a cycle in which any of these is true:
//       (a) a transfer with the owner's last asserted;
//       (b) a transfer where count == MAX_BURST-1 (only when MAX_BURST != 0);
//       (c) the owner's req is low (dropped mid-burst; no transfer occurs that cycle).
//   - On release: the pointer favours the other requester and the count clears. Next state:
//       other requester asserted          -> go directly to its GNT state (back-to-back, no idle cycle);
//       else owner still asserted         -> same GNT state again (new burst);
//       else                              -> IDLE.
//   - out_ready low stalls the transfer. The grant, sel and count hold, and data must be held by the requester.
//   - A req that rises while the other requester owns the channel waits. It is not starved: round-robin
//     plus MAX_BURST bound its wait to MAX_BURST+1 cycles when out_ready is held high.
//   - Reset asserted mid-burst forces the reset state on the next edge. The in-flight beat is abandoned.
//   - Count width is $clog2(MAX_BURST+1). With MAX_BURST=0 the counter is unused and release
//     happens via (a) or (c) only.
// CONFIGURATION
//   - Macro MUX_ARB_STATS_EN defined: adds outputs gcnt0[15:0] and gcnt1[15:0].
//     Each counts grants issued (entries into GNT0/GNT1), saturates at 16'hFFFF, and clears on rst.
//   - Macro undefined: these ports and counters do not exist. Core behaviour is identical.
// STRUCTURE
//   - mux_arb_defs.vh: state encodings ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2, and the stats counter width.
//     Shared with the testbench.
//   - Sub-module: the existing mux2a1, instantiated WIDTH times in a generate loop.
//     Port order is (D0, D1, S, Y); each slice takes d0[i], d1[i], sel and drives out_data[i].
//   - FSM, pointer and counter live in this module; no further sub-modules.
// TESTING (bench tbmux2a1arbiter, writes tbmux2a1arbiter_tb.vcd, uses $monitor)
//   1. rst=1 for 2 cycles -> gnt0=gnt1=0, sel=0, out_valid=0, busy=0.
//   2. req0=1 only, d0=8'hA5, out_ready=1, last0 on beat 2 -> gnt0 one cycle after req0;
//      out_data=8'hA5 for 2 beats; then gnt0 is released and, with req0 still asserted, regranted.
//   3. req0=req1=1 from reset, out_ready=1, no last -> GNT0 for 4 beats (MAX_BURST), then GNT1 with
//      sel=1 and out_data=d1 for 4 beats; alternation continues with no idle cycle between grants.
//   4. GNT1 active, out_ready=0 for 3 cycles -> gnt1, sel and out_data stable; count frozen; out_valid=1 throughout.
//   5. GNT0 at beat 1, req0 dropped -> out_valid=0 that cycle; next cycle GNT1 if req1=1, else IDLE.
//   6. rst pulsed mid-burst in GNT1 -> next cycle IDLE, gnt1=0, sel=0; after release, req0 is favoured.
//      With MUX_ARB_STATS_EN defined, gcnt0/gcnt1 read 0 after rst and then match the grant count of scenario 3.

Source files
------------

// File: rtl/mux2a1_arbiter_pkg.sv
// Shared definitions for the mux2a1 round-robin arbiter: state encodings and stats counter width.
package mux2a1_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/mux2a1.sv
// One-bit 2:1 mux slice of the shared datapath.
module mux2a1 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux2a1_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared 2:1 mux channel.
// Optional grant statistics outputs (gcnt0/gcnt1) are enabled by defining MUX_ARB_STATS_EN.
module mux2a1_arbiter
    import mux2a1_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             last0,
    input  logic             last1,
    input  logic             out_ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] gcnt0,
    output logic [STATS_W-1:0] gcnt1
`endif
);

    // Counter needs at least one bit even when bursts are unlimited.
    localparam int unsigned CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    state_t        state;
    state_t        nxt_state;
    logic          ptr;        // 0 favours req0, 1 favours req1
    logic [CW-1:0] cnt;

    logic owner_is1;
    logic in_gnt;
    logic owner_req;
    logic owner_last;
    logic other_req;
    logic xfer;
    logic burst_end;
    logic release_g;

    assign owner_is1  = (state == ST_GNT1);
    assign in_gnt     = (state == ST_GNT0) || (state == ST_GNT1);
    assign owner_req  = owner_is1 ? req1 : req0;
    assign owner_last = owner_is1 ? last1 : last0;
    assign other_req  = owner_is1 ? req0 : req1;

    assign out_valid  = ((state == ST_GNT0) && req0) || ((state == ST_GNT1) && req1);
    assign xfer       = out_valid && out_ready;
    assign burst_end  = (MAX_BURST != 0) && (cnt == CW'(MAX_BURST - 1));
    assign release_g  = in_gnt && (!owner_req || (xfer && (owner_last || burst_end)));

    // Next-state selection: pointer-based pick from IDLE, hand-over or re-grant on release.
    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: begin
                if (req0 && (!ptr || !req1)) begin
                    nxt_state = ST_GNT0;
                end else if (req1) begin
                    nxt_state = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (release_g) begin
                    if (other_req) begin
                        nxt_state = owner_is1 ? ST_GNT0 : ST_GNT1;
                    end else if (owner_req) begin
                        nxt_state = state;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // State, pointer, beat counter and registered grant/select outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= nxt_state;
            gnt0  <= (nxt_state == ST_GNT0);
            gnt1  <= (nxt_state == ST_GNT1);
            sel   <= (nxt_state == ST_GNT1);
            busy  <= (nxt_state != ST_IDLE);
            if (release_g) begin
                ptr <= !owner_is1;
                cnt <= '0;
            end else if (xfer) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Datapath: one mux2a1 slice per data bit, all steered by the registered select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2a1 u_mux (
            .d0 (d0[i]),
            .d1 (d1[i]),
            .s  (sel),
            .y  (out_data[i])
        );
    end

`ifdef MUX_ARB_STATS_EN
    logic new_grant;

    // A grant is issued on entry from IDLE or on any release that lands in a GNT state.
    assign new_grant = (nxt_state != ST_IDLE) && ((state == ST_IDLE) || release_g);

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else begin
            if (new_grant && (nxt_state == ST_GNT0) && (gcnt0 != {STATS_W{1'b1}})) begin
                gcnt0 <= gcnt0 + STATS_W'(1);
            end
            if (new_grant && (nxt_state == ST_GNT1) && (gcnt1 != {STATS_W{1'b1}})) begin
                gcnt1 <= gcnt1 + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2a1_arbiter.sv
// Self-checking bench for mux2a1_arbiter: directed vector table plus randomized run against a
// behavioural owner/beat/favour model. Handles MUX_ARB_STATS_EN builds as well.
module tb_mux2a1_arbiter;

    localparam int MAXB = 4;

    logic       clk;
    logic       rst;
    logic       req0, req1, last0, last1, out_ready;
    logic [7:0] d0, d1;
    logic       gnt0, gnt1, sel, out_valid, busy;
    logic [7:0] out_data;
`ifdef MUX_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1;
`endif

    mux2a1_arbiter #(.WIDTH(8), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .d0        (d0),
        .d1        (d1),
        .last0     (last0),
        .last1     (last1),
        .out_ready (out_ready),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MUX_ARB_STATS_EN
        ,
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: who owns the channel (-1 = nobody), beats taken, who is favoured.
    int m_owner = -1;
    int m_beats = 0;
    int m_fav   = 0;
    int m_gc[2] = '{0, 0};
    logic rq[2];
    logic ls[2];

    // Observed values from the last step, for table comparisons.
    logic       o_valid, o_g0, o_g1, o_sel, o_busy;
    logic [7:0] o_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic give(input int who);
        m_owner = who;
        m_gc[who]++;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic r, x, done;
        if (rst) begin
            m_owner = -1; m_beats = 0; m_fav = 0; m_gc[0] = 0; m_gc[1] = 0;
        end else if (m_owner < 0) begin
            if (rq[m_fav]) give(m_fav);
            else if (rq[1 - m_fav]) give(1 - m_fav);
        end else begin
            r    = rq[m_owner];
            x    = r && out_ready;
            done = !r || (x && (ls[m_owner] || (MAXB != 0 && m_beats + 1 == MAXB)));
            if (done) begin
                m_fav   = 1 - m_owner;
                m_beats = 0;
                if (rq[1 - m_owner]) give(1 - m_owner);
                else if (r) give(m_owner);
                else m_owner = -1;
            end else if (x) begin
                m_beats++;
            end
        end
    endtask

    // Apply one cycle of inputs, check combinational outputs, clock, check registered outputs.
    task automatic step(input logic r, input logic q0, input logic q1, input logic l0,
                        input logic l1, input logic rdy, input logic [7:0] a, input logic [7:0] b);
        logic ev;
        rst = r; req0 = q0; req1 = q1; last0 = l0; last1 = l1; out_ready = rdy; d0 = a; d1 = b;
        rq[0] = q0; rq[1] = q1; ls[0] = l0; ls[1] = l1;
        #1;
        ev = (m_owner >= 0) && rq[m_owner];
        o_valid = out_valid; o_data = out_data;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data", 32'(out_data), 32'((m_owner == 1) ? b : a));
        @(posedge clk);
        model_edge();
        #1;
        o_g0 = gnt0; o_g1 = gnt1; o_sel = sel; o_busy = busy;
        chk("gnt0", 32'(gnt0), 32'(m_owner == 0));
        chk("gnt1", 32'(gnt1), 32'(m_owner == 1));
        chk("sel", 32'(sel), 32'(m_owner == 1));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
`ifdef MUX_ARB_STATS_EN
        chk("gcnt0", 32'(gcnt0), 32'((m_gc[0] > 65535) ? 65535 : m_gc[0]));
        chk("gcnt1", 32'(gcnt1), 32'((m_gc[1] > 65535) ? 65535 : m_gc[1]));
`endif
    endtask

    typedef struct {
        logic       r, q0, q1, l0, l1, rdy;
        logic       v, g0, g1, s, b;
        logic [7:0] dat;
    } row_t;

    row_t tbl[30];

    initial begin
        logic q0r, q1r;
        // Directed rows: inputs | pre-edge valid, post-edge gnt0 gnt1 sel busy, pre-edge data.
        tbl[0]  = '{0,1,0,0,0,1, 0,1,0,0,1, 8'hA5};
        tbl[1]  = '{0,1,0,0,0,1, 1,1,0,0,1, 8'hA5};
        tbl[2]  = '{0,1,0,1,0,1, 1,1,0,0,1, 8'hA5};
        tbl[3]  = '{0,0,0,0,0,1, 0,0,0,0,0, 8'hA5};
        tbl[4]  = '{1,1,1,0,0,1, 0,0,0,0,0, 8'hA5};
        tbl[5]  = '{0,1,1,0,0,1, 0,1,0,0,1, 8'hA5};
        tbl[6]  = '{0,1,1,0,0,1, 1,1,0,0,1, 8'hA5};
        tbl[7]  = '{0,1,1,0,0,1, 1,1,0,0,1, 8'hA5};
        tbl[8]  = '{0,1,1,0,0,1, 1,1,0,0,1, 8'hA5};
        tbl[9]  = '{0,1,1,0,0,1, 1,0,1,1,1, 8'hA5};
        tbl[10] = '{0,1,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[11] = '{0,1,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[12] = '{0,1,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[13] = '{0,1,1,0,0,1, 1,1,0,0,1, 8'h3C};
        tbl[14] = '{0,1,1,0,0,1, 1,1,0,0,1, 8'hA5};
        tbl[15] = '{0,0,1,0,0,1, 0,0,1,1,1, 8'hA5};
        tbl[16] = '{0,0,0,0,0,1, 0,0,0,0,0, 8'h3C};
        tbl[17] = '{1,0,0,0,0,1, 0,0,0,0,0, 8'hA5};
        tbl[18] = '{0,0,1,0,0,1, 0,0,1,1,1, 8'hA5};
        tbl[19] = '{0,0,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[20] = '{0,0,1,0,0,0, 1,0,1,1,1, 8'h3C};
        tbl[21] = '{0,0,1,0,0,0, 1,0,1,1,1, 8'h3C};
        tbl[22] = '{0,0,1,0,0,0, 1,0,1,1,1, 8'h3C};
        tbl[23] = '{0,1,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[24] = '{0,1,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[25] = '{0,1,1,0,0,1, 1,1,0,0,1, 8'h3C};
        tbl[26] = '{0,0,1,0,0,1, 0,0,1,1,1, 8'hA5};
        tbl[27] = '{0,0,1,0,0,1, 1,0,1,1,1, 8'h3C};
        tbl[28] = '{1,1,1,0,0,1, 1,0,0,0,0, 8'h3C};
        tbl[29] = '{0,1,1,0,0,1, 0,1,0,0,1, 8'hA5};

        // Two reset cycles, then check the reset state.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        out_ready = 1'b0; d0 = 8'hA5; d1 = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        chk("rst_sel", 32'(sel), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_data", 32'(out_data), 32'(8'hA5));

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].r, tbl[i].q0, tbl[i].q1, tbl[i].l0, tbl[i].l1, tbl[i].rdy, 8'hA5, 8'h3C);
            chk($sformatf("row%0d_valid", i), 32'(o_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d_data", i), 32'(o_data), 32'(tbl[i].dat));
            chk($sformatf("row%0d_gnt0", i), 32'(o_g0), 32'(tbl[i].g0));
            chk($sformatf("row%0d_gnt1", i), 32'(o_g1), 32'(tbl[i].g1));
            chk($sformatf("row%0d_sel", i), 32'(o_sel), 32'(tbl[i].s));
            chk($sformatf("row%0d_busy", i), 32'(o_busy), 32'(tbl[i].b));
        end

        // Randomized traffic with sticky request levels, against the model.
        q0r = 1'b0; q1r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) q0r = ~q0r;
            if ($urandom_range(7) == 0) q1r = ~q1r;
            step(($urandom_range(99) == 0), q0r, q1r,
                 ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(3) != 0), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
